// File: rtl/xor_stream_descrambler.sv
// Purpose: framed additive descrambler, XORs each 16-bit word with an LFSR keystream word.
// Latency: 1 cycle from input accept to out_valid; 1 word/cycle while out_ready=1.
// Backpressure: in_ready drops while a held output word is stalled by out_ready=0 or a seed loads.
//
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   seed_load, seed     - strobe that loads a new key (zero seed -> DEFAULT_SEED) and starts a frame
//   in_valid/in_ready   - scrambled word handshake, in_data carries the word
//   out_valid/out_ready - descrambled word handshake, out_data is registered
//   busy                - frame in progress
//   frame_done          - one-cycle pulse after the last word of a frame is accepted
module xor_stream_descrambler #(
    parameter int          FRAME_LEN    = 64,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] key;
    logic [15:0] key_next;
    logic [15:0] count;
    logic        fb;
    logic        accept;
    logic        last_word;

    // x^16+x^14+x^13+x^11+1; a non-zero key never maps to zero, and the
    // seed path substitutes DEFAULT_SEED for zero, so the key stays non-zero.
    assign fb       = key[15] ^ key[13] ^ key[12] ^ key[10];
    assign key_next = {key[14:0], fb};

    // A seed load takes priority over data, so no word is consumed with a stale key.
    assign in_ready  = (state == RUN) & ~seed_load & (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign last_word = (count == LAST_IDX);
    assign busy      = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (seed_load) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (seed_load) begin
                    state_nxt = RUN;
                end else if (accept && last_word) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Keystream and frame position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key   <= 16'h0000;
            count <= 16'h0000;
        end else if (seed_load) begin
            key   <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
            count <= 16'h0000;
        end else if (accept) begin
            key   <= key_next;
            count <= count + 16'h0001;
        end
    end

    // Single output stage; a seed load leaves a pending word untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ key;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept & last_word;
        end
    end

endmodule

// File: tb/tb_xor_stream_descrambler.sv
module tb_xor_stream_descrambler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seed_load;
    logic [15:0] seed;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    xor_stream_descrambler #(
        .FRAME_LEN   (4),
        .DEFAULT_SEED(16'hACE1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; registered outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed_load = 1'b1;
        seed      = s;
        tick();
        seed_load = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        seed_load = 1'b0;
        seed      = 16'h0000;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        out_ready = 1'b1;

        // Reset state with traffic offered
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_out_data", out_data, 16'h0000);

        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_busy", busy, 0);

        // Keystream from seed ACE1
        in_valid = 1'b0;
        load_seed(16'hACE1);
        chk("ks_busy", busy, 1);
        in_valid = 1'b1;
        in_data  = 16'h0000;
        #1;
        chk("ks_in_ready", in_ready, 1);
        tick();
        chk("ks_w1_valid", out_valid, 1);
        chk("ks_w1_data", out_data, 16'hACE1);
        tick();
        chk("ks_w2_data", out_data, 16'h59C3);
        in_valid = 1'b0;
        tick();
        chk("ks_drain_valid", out_valid, 0);

        load_seed(16'hACE1);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        tick();
        chk("ks_ffff_data", out_data, 16'h531E);
        in_valid = 1'b0;
        tick();

        // Backpressure
        load_seed(16'hACE1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        tick();
        chk("bp_w1_data", out_data, 16'hBED5);
        in_data = 16'h5678;
        #1;
        chk("bp_in_ready_low", in_ready, 0);
        tick();
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data", out_data, 16'hBED5);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", in_ready, 1);
        tick();
        chk("bp_w2_data", out_data, 16'h0FBB);
        in_valid = 1'b0;
        tick();
        chk("bp_drain_valid", out_valid, 0);

        // Zero seed substitutes the default
        load_seed(16'h0000);
        in_valid = 1'b1;
        in_data  = 16'h0000;
        tick();
        chk("zs_data", out_data, 16'hACE1);
        in_valid = 1'b0;
        tick();

        // Frame end with FRAME_LEN=4
        load_seed(16'hACE1);
        in_valid = 1'b1;
        in_data  = 16'h0000;
        tick();
        tick();
        tick();
        chk("fe_w3_data", out_data, 16'hB387);
        chk("fe_w3_done", frame_done, 0);
        chk("fe_w3_busy", busy, 1);
        tick();
        chk("fe_w4_data", out_data, 16'h670F);
        chk("fe_done", frame_done, 1);
        chk("fe_busy", busy, 0);
        chk("fe_in_ready", in_ready, 0);
        tick();
        chk("fe_done_pulse", frame_done, 0);
        chk("fe_drained", out_valid, 0);
        tick();
        chk("fe_ignored", out_valid, 0);

        load_seed(16'hACE1);
        tick();
        chk("fe_restart_data", out_data, 16'hACE1);

        // Mid-frame reseed with a word offered
        seed_load = 1'b1;
        seed      = 16'h1234;
        #1;
        chk("mf_in_ready", in_ready, 0);
        tick();
        seed_load = 1'b0;
        chk("mf_not_accepted", out_valid, 0);
        tick();
        chk("mf_new_key", out_data, 16'h1234);
        chk("mf_valid", out_valid, 1);

        // Asynchronous reset while a word is held
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_out_data", out_data, 16'h0000);
        chk("ar_busy", busy, 0);
        chk("ar_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
